rpn_eval: RTL and testbench



---
 rtl/rpn_pkg.sv | 30 +++
 rtl/rpn_alu.sv | 39 +++
 rtl/rpn_eval.sv | 170 +++++++++++++++++
 tb/tb_rpn_eval.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rpn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rpn_pkg
// Description : Shared token codes, sizing constants and FSM encoding for the
//               postfix evaluator family.
// Revision    : 1.0 - initial release
// ============================================================================
package rpn_pkg;

    localparam int N_TOK   = 19;
    localparam int TOK_W   = 5;
    localparam int DATA_W  = 41;
    localparam int STACK_D = 10;

    localparam int CNT_W = $clog2(N_TOK);
    localparam int SP_W  = $clog2(STACK_D + 1);

    localparam logic [TOK_W-1:0] TOK_ADD = 5'd16;
    localparam logic [TOK_W-1:0] TOK_SUB = 5'd17;
    localparam logic [TOK_W-1:0] TOK_MUL = 5'd18;
    localparam logic [TOK_W-1:0] TOK_DIV = 5'd19;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rpn_alu.sv
`default_nettype none
// ============================================================================
// Module      : rpn_alu
// Description : Combinational signed a op b for the four postfix operators;
//               divide by zero yields 0 and raises div_by_zero.
// Revision    : 1.0 - initial release
// ============================================================================
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int W = 41
) (
    input  logic signed [W-1:0]     a,
    input  logic signed [W-1:0]     b,
    input  logic        [TOK_W-1:0] op,
    output logic signed [W-1:0]     result,
    output logic                    div_by_zero
);

    always_comb begin
        result      = '0;
        div_by_zero = 1'b0;
        case (op)
            TOK_ADD: result = a + b;
            TOK_SUB: result = a - b;
            TOK_MUL: result = a * b;
            TOK_DIV: begin
                if (b == '0) begin
                    div_by_zero = 1'b1;
                end else begin
                    result = a / b;
                end
            end
            default: result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rpn_eval.sv
`default_nettype none
// ============================================================================
// Module      : rpn_eval
// Description : Evaluates one packed 19-token postfix word, one token per
//               cycle, on a 10-deep operand stack. Define RPN_ERR_EN to add
//               the err output and malformed-expression checking.
// Revision    : 1.0 - initial release
// ============================================================================
module rpn_eval
    import rpn_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [N_TOK*TOK_W-1:0]    in_rpn,
    output logic                      busy,
    output logic                      out_valid,
    output logic signed [DATA_W-1:0]  out
`ifdef RPN_ERR_EN
    ,
    output logic                      err
`endif
);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [N_TOK*TOK_W-1:0]    r_shift;
    logic [CNT_W-1:0]          r_cnt;
    logic [SP_W-1:0]           r_sp;
    logic signed [DATA_W-1:0]  r_stack [STACK_D];
    logic                      r_out_valid;
    logic signed [DATA_W-1:0]  r_out;
    logic [TOK_W-1:0]          w_tok;
    logic signed [DATA_W-1:0]  w_alu_res;

`ifdef RPN_ERR_EN
    logic r_err;
    logic r_err_acc;
    logic w_div_by_zero;
    logic w_final_err;

    assign w_final_err = r_err_acc | (r_sp != SP_W'(1));
    assign err         = r_err;
`endif

    // Token 0 sits in the top bits; the word shifts left as tokens retire.
    assign w_tok     = r_shift[N_TOK*TOK_W-1 -: TOK_W];
    assign out_valid = r_out_valid;
    assign out       = r_out;

    // Stack is kept top-first: r_stack[0] is top of stack, r_stack[1] below it.
    rpn_alu #(
        .W (DATA_W)
    ) u_alu (
        .a           (r_stack[1]),
        .b           (r_stack[0]),
        .op          (w_tok),
        .result      (w_alu_res),
`ifdef RPN_ERR_EN
        .div_by_zero (w_div_by_zero)
`else
        .div_by_zero ()
`endif
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = EVAL;
            EVAL:    if (r_cnt == CNT_W'(N_TOK - 1)) w_state_nxt = DONE;
            DONE:    if (r_out_valid) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != IDLE);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_shift     <= '0;
            r_cnt       <= '0;
            r_sp        <= '0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            for (int i = 0; i < STACK_D; i++) begin
                r_stack[i] <= '0;
            end
`ifdef RPN_ERR_EN
            r_err       <= 1'b0;
            r_err_acc   <= 1'b0;
`endif
        end else begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
`ifdef RPN_ERR_EN
            r_err       <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_shift   <= in_rpn;
                        r_cnt     <= '0;
                        r_sp      <= '0;
`ifdef RPN_ERR_EN
                        r_err_acc <= 1'b0;
`endif
                    end
                end
                EVAL: begin
                    r_shift <= {r_shift[N_TOK*TOK_W-TOK_W-1:0], {TOK_W{1'b0}}};
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_tok < TOK_ADD) begin
                        if (r_sp < SP_W'(STACK_D)) begin
                            r_stack[0] <= {{(DATA_W-TOK_W){1'b0}}, w_tok};
                            for (int i = 1; i < STACK_D; i++) begin
                                r_stack[i] <= r_stack[i-1];
                            end
                            r_sp <= r_sp + SP_W'(1);
`ifdef RPN_ERR_EN
                        end else begin
                            r_err_acc <= 1'b1;
`endif
                        end
                    end else if (w_tok <= TOK_DIV) begin
                        if (r_sp >= SP_W'(2)) begin
                            r_stack[0] <= w_alu_res;
                            for (int i = 1; i < STACK_D - 1; i++) begin
                                r_stack[i] <= r_stack[i+1];
                            end
                            r_stack[STACK_D-1] <= '0;
                            r_sp <= r_sp - SP_W'(1);
`ifdef RPN_ERR_EN
                            if (w_div_by_zero) r_err_acc <= 1'b1;
`endif
                        end else begin
                            r_sp <= '0;
`ifdef RPN_ERR_EN
                            r_err_acc <= 1'b1;
`endif
                        end
                    end
                end
                DONE: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
`ifdef RPN_ERR_EN
                        r_err       <= w_final_err;
                        r_out       <= w_final_err ? '0 : r_stack[0];
`else
                        r_out       <= r_stack[0];
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rpn_eval.sv
`default_nettype none
// ============================================================================
// Module      : tb_rpn_eval
// Description : Self-checking bench for rpn_eval: queue-based postfix model,
//               per-cycle output compare and directed literal vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rpn_eval;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic [94:0]        in_rpn = '0;
    logic               busy;
    logic               out_valid;
    logic signed [40:0] out;
`ifdef RPN_ERR_EN
    logic               err;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    rpn_eval dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_rpn    (in_rpn),
        .busy      (busy),
        .out_valid (out_valid),
        .out       (out)
`ifdef RPN_ERR_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference evaluation straight from the token rules, on an unbounded queue.
    function automatic void model(input logic [94:0] w, output logic signed [40:0] res,
                                  output bit dz, output bit mal);
        longint st[$];
        longint a, b, r;
        logic [4:0] t;
        dz  = 1'b0;
        mal = 1'b0;
        for (int i = 0; i < 19; i++) begin
            t = w[94-5*i -: 5];
            if (t < 5'd16) begin
                if (st.size() == 10) mal = 1'b1;
                else st.push_back(longint'(t));
            end else if (t <= 5'd19) begin
                if (st.size() < 2) begin
                    mal = 1'b1;
                    st.delete();
                end else begin
                    b = st.pop_back();
                    a = st.pop_back();
                    case (t)
                        5'd16:   r = a + b;
                        5'd17:   r = a - b;
                        5'd18:   r = a * b;
                        default: begin
                            if (b == 0) begin dz = 1'b1; r = 0; end
                            else r = a / b;
                        end
                    endcase
                    st.push_back(r);
                end
            end
        end
        if (st.size() != 1) mal = 1'b1;
        res = (st.size() > 0) ? 41'(st[0]) : '0;
    endfunction

    function automatic logic [94:0] pack(input logic [4:0] q[$]);
        logic [94:0] w;
        w = '0;
        for (int i = 0; i < 19; i++) w[94-5*i -: 5] = (i < q.size()) ? q[i] : 5'd20;
        return w;
    endfunction

    // Timeline model: job accepted when idle, result due 20 edges after capture.
    int                 cyc      = 0;
    bit                 m_active = 1'b0;
    int                 m_start  = 0;
    logic signed [40:0] m_res    = '0;
    bit                 m_care   = 1'b0;
    bit                 m_err    = 1'b0;

    initial begin
        logic signed [40:0] r;
        bit dz, mal;
        forever begin
            @(posedge clk or posedge rst_n);
            if (rst_n) begin
                m_active = 1'b0;
            end else begin
                cyc++;
                if (m_active && cyc == m_start + 21) begin
                    m_active = 1'b0;
                end else if (!m_active && in_valid) begin
                    m_active = 1'b1;
                    m_start  = cyc;
                    model(in_rpn, r, dz, mal);
`ifdef RPN_ERR_EN
                    m_err  = dz | mal;
                    m_res  = m_err ? '0 : r;
                    m_care = 1'b1;
`else
                    m_err  = 1'b0;
                    m_res  = r;
                    m_care = !mal;
`endif
                end
            end
        end
    end

    initial begin
        bit ev;
        forever begin
            @(negedge clk);
            ev = m_active && (cyc == m_start + 20);
            chk("busy", busy, m_active);
            chk("out_valid", out_valid, ev);
            if (!ev) chk("out_idle_zero", out, 0);
            else if (m_care) chk("out_model", out, m_res);
`ifdef RPN_ERR_EN
            chk("err", err, ev ? m_err : 1'b0);
`endif
        end
    end

    task automatic run_job(input logic [94:0] w, input int inject_at, input logic [94:0] w2,
                           output logic signed [40:0] got, output int bcnt, output bit seen);
        int i;
        got  = '0;
        bcnt = 0;
        seen = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_rpn   = w;
        @(negedge clk);
        in_valid = 1'b0;
        i = 0;
        while (i < 40) begin
            if (busy) bcnt++;
            if (out_valid) begin seen = 1'b1; got = out; end
            if (seen && !busy) break;
            if (i == inject_at) begin in_valid = 1'b1; in_rpn = w2; end
            else in_valid = 1'b0;
            @(negedge clk);
            i++;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] q[$];
        logic [94:0] w_pow2, w_pow15, w_sub, w_div, w_dz, w_nop, w_bad;
        logic signed [40:0] mr, got;
        bit mdz, mmal, seen;
        int bc;

        q = {}; repeat (10) q.push_back(5'd2);  repeat (9) q.push_back(5'd18); w_pow2  = pack(q);
        q = {}; repeat (10) q.push_back(5'd15); repeat (9) q.push_back(5'd18); w_pow15 = pack(q);
        q = {5'd1, 5'd2, 5'd17};
        repeat (8) begin q.push_back(5'd0); q.push_back(5'd16); end
        w_sub = pack(q);
        q = {5'd0, 5'd7, 5'd17, 5'd2, 5'd19};
        repeat (7) begin q.push_back(5'd1); q.push_back(5'd18); end
        w_div = pack(q);
        q = {5'd5, 5'd0, 5'd19};
        repeat (8) begin q.push_back(5'd1); q.push_back(5'd18); end
        w_dz = pack(q);
        q = {5'd3, 5'd4, 5'd16};
        repeat (16) q.push_back(5'd31);
        w_nop = pack(q);
        q = {5'd16, 5'd1};
        repeat (8) begin q.push_back(5'd1); q.push_back(5'd18); end
        w_bad = pack(q);

        model(w_pow2, mr, mdz, mmal);  chk("model_pow2", mr, 1024);
        model(w_pow15, mr, mdz, mmal); chk("model_pow15", mr, 64'sd576650390625);
        model(w_div, mr, mdz, mmal);   chk("model_div", mr, -3);
        model(w_dz, mr, mdz, mmal);    chk("model_dz_flag", mdz, 1);
        model(w_bad, mr, mdz, mmal);   chk("model_bad_flag", mmal, 1);

        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out", out, 0);

        run_job(w_pow2, -1, '0, got, bc, seen);
        chk("pow2_seen", seen, 1);
        chk("pow2_out", got, 1024);
        chk("pow2_busy_cycles", bc, 21);

        run_job(w_pow15, -1, '0, got, bc, seen);
        chk("pow15_out", got, 64'sd576650390625);
        run_job(w_sub, -1, '0, got, bc, seen);
        chk("sub_order_out", got, -1);
        run_job(w_div, -1, '0, got, bc, seen);
        chk("div_trunc_out", got, -3);
        run_job(w_nop, -1, '0, got, bc, seen);
        chk("noop_out", got, 7);
        run_job(w_dz, -1, '0, got, bc, seen);
        chk("div0_out", got, 0);

        run_job(w_bad, -1, '0, got, bc, seen);
        chk("bad_seen", seen, 1);
`ifdef RPN_ERR_EN
        chk("bad_out_forced", got, 0);
`endif

        run_job(w_pow2, 5, w_pow15, got, bc, seen);
        chk("inject_ignored_out", got, 1024);
        chk("inject_busy_cycles", bc, 21);

        @(negedge clk);
        in_valid = 1'b1;
        in_rpn   = w_pow15;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("reset_midjob_no_valid", seen, 0);

        run_job(w_sub, -1, '0, got, bc, seen);
        chk("after_reset_out", got, -1);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
